pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 107 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, memory-wait freeze and branch flush,
// with a sticky memory-wait timeout flag and a running count of stalled cycles.
module pipe_hazard_ctrl #(
   parameter int unsigned WAIT_MAX = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [4:0]  id_rs1_addr_i,
   input  logic [4:0]  id_rs2_addr_i,
   input  logic        ex_memread_i,
   input  logic [4:0]  ex_rd_addr_i,
   input  logic        branch_taken_i,
   input  logic        mem_req_i,
   input  logic        mem_ack_i,
   output logic        pc_write_o,
   output logic        ifid_write_o,
   output logic        ifid_flush_o,
   output logic        idex_bubble_o,
   output logic        pipe_hold_o,
   output logic        timeout_o,
   output logic [15:0] stall_cnt_o
);

   typedef enum logic {RUN, MEM_WAIT} state_t;

   localparam logic [7:0] WAIT_MAX_C = 8'(WAIT_MAX);

   state_t      state_q, state_d;
   logic [7:0]  wait_cnt_q, wait_cnt_d;
   logic        timeout_q, timeout_d;
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic        mem_stall;
   logic        load_use;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      pc_write_o    = 1'b1;
      ifid_write_o  = 1'b1;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b0;
      pipe_hold_o   = 1'b0;
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;

      // Once waiting, only the acknowledge ends the freeze.
      if (state_q == MEM_WAIT) begin
         mem_stall = ~mem_ack_i;
      end else begin
         mem_stall = mem_req_i & ~mem_ack_i;
      end

      load_use = ex_memread_i && (ex_rd_addr_i != 5'd0) &&
                 ((ex_rd_addr_i == id_rs1_addr_i) || (ex_rd_addr_i == id_rs2_addr_i));

      if (rst_i) begin
         pc_write_o = 1'b1;
      end else if (mem_stall) begin
         pipe_hold_o  = 1'b1;
         pc_write_o   = 1'b0;
         ifid_write_o = 1'b0;
      end else if (load_use) begin
         pc_write_o    = 1'b0;
         ifid_write_o  = 1'b0;
         idex_bubble_o = 1'b1;
      end else if (branch_taken_i) begin
         ifid_flush_o = 1'b1;
      end

      case (state_q)
         RUN: begin
            if (mem_stall) begin
               state_d    = MEM_WAIT;
               wait_cnt_d = '0;
            end
         end
         MEM_WAIT: begin
            if (wait_cnt_q != WAIT_MAX_C) begin
               wait_cnt_d = wait_cnt_q + 8'd1;
            end
            if (mem_ack_i) begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase

      timeout_d   = timeout_q | ((state_q == MEM_WAIT) && (wait_cnt_d == WAIT_MAX_C));
      stall_cnt_d = stall_cnt_q + {15'd0, ~pc_write_o};
   end

   assign timeout_o   = timeout_q;
   assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

   localparam int WAIT_MAX = 255;

   logic        clk_i;
   logic        rst_i;
   logic [4:0]  id_rs1_addr_i;
   logic [4:0]  id_rs2_addr_i;
   logic        ex_memread_i;
   logic [4:0]  ex_rd_addr_i;
   logic        branch_taken_i;
   logic        mem_req_i;
   logic        mem_ack_i;
   logic        pc_write_o;
   logic        ifid_write_o;
   logic        ifid_flush_o;
   logic        idex_bubble_o;
   logic        pipe_hold_o;
   logic        timeout_o;
   logic [15:0] stall_cnt_o;

   int checks = 0;
   int errors = 0;

   // Reference model state: are we waiting on memory, how long, sticky timeout, stall tally.
   bit mWaiting;
   int mWaitCycles;
   bit mTimeout;
   int mStallCnt;

   pipe_hazard_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .id_rs1_addr_i  (id_rs1_addr_i),
      .id_rs2_addr_i  (id_rs2_addr_i),
      .ex_memread_i   (ex_memread_i),
      .ex_rd_addr_i   (ex_rd_addr_i),
      .branch_taken_i (branch_taken_i),
      .mem_req_i      (mem_req_i),
      .mem_ack_i      (mem_ack_i),
      .pc_write_o     (pc_write_o),
      .ifid_write_o   (ifid_write_o),
      .ifid_flush_o   (ifid_flush_o),
      .idex_bubble_o  (idex_bubble_o),
      .pipe_hold_o    (pipe_hold_o),
      .timeout_o      (timeout_o),
      .stall_cnt_o    (stall_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // One comparison: count it, and report it when observed and expected differ.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      mWaiting    = 1'b0;
      mWaitCycles = 0;
      mTimeout    = 1'b0;
      mStallCnt   = 0;
   endtask

   // Drive one cycle of inputs (called 1 time unit after a rising edge), check the
   // Mealy outputs mid-cycle, then advance the model across the next rising edge.
   task automatic applyStimulus(input logic [4:0] rs1, input logic [4:0] rs2, input bit memread,
                                input logic [4:0] rd, input bit br, input bit req, input bit ack);
      bit memStall, loadUse;
      bit ePc, eIfid, eFlush, eBubble, eHold;
      id_rs1_addr_i  = rs1;
      id_rs2_addr_i  = rs2;
      ex_memread_i   = memread;
      ex_rd_addr_i   = rd;
      branch_taken_i = br;
      mem_req_i      = req;
      mem_ack_i      = ack;
      #4;
      memStall = mWaiting ? !ack : (req && !ack);
      loadUse  = memread && (rd != 0) && (rd == rs1 || rd == rs2);
      eHold    = memStall;
      eBubble  = !memStall && loadUse;
      ePc      = !memStall && !loadUse;
      eIfid    = ePc;
      eFlush   = ePc && br;
      checkOutput("pc_write", 32'(pc_write_o), 32'(ePc));
      checkOutput("ifid_write", 32'(ifid_write_o), 32'(eIfid));
      checkOutput("ifid_flush", 32'(ifid_flush_o), 32'(eFlush));
      checkOutput("idex_bubble", 32'(idex_bubble_o), 32'(eBubble));
      checkOutput("pipe_hold", 32'(pipe_hold_o), 32'(eHold));
      checkOutput("timeout", 32'(timeout_o), 32'(mTimeout));
      checkOutput("stall_cnt", 32'(stall_cnt_o), 32'(mStallCnt));
      @(posedge clk_i);
      if (!ePc) mStallCnt = (mStallCnt + 1) % 65536;
      if (mWaiting) begin
         if (mWaitCycles < WAIT_MAX) mWaitCycles++;
         if (mWaitCycles == WAIT_MAX) mTimeout = 1'b1;
         if (ack) mWaiting = 1'b0;
      end else if (memStall) begin
         mWaiting    = 1'b1;
         mWaitCycles = 0;
      end
      #1;
   endtask

   task automatic idleCycle();
      applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // Assert reset mid-cycle, check the reset-time outputs, release it after an edge.
   task automatic applyReset();
      rst_i = 1'b1;
      #2;
      modelReset();
      checkOutput("rst_pc_write", 32'(pc_write_o), 32'd1);
      checkOutput("rst_ifid_write", 32'(ifid_write_o), 32'd1);
      checkOutput("rst_ifid_flush", 32'(ifid_flush_o), 32'd0);
      checkOutput("rst_idex_bubble", 32'(idex_bubble_o), 32'd0);
      checkOutput("rst_pipe_hold", 32'(pipe_hold_o), 32'd0);
      checkOutput("rst_timeout", 32'(timeout_o), 32'd0);
      checkOutput("rst_stall_cnt", 32'(stall_cnt_o), 32'd0);
      @(posedge clk_i);
      #1;
      rst_i = 1'b0;
   endtask

   initial begin
      bit req, ack, br, memread;
      rst_i          = 1'b1;
      id_rs1_addr_i  = '0;
      id_rs2_addr_i  = '0;
      ex_memread_i   = 1'b0;
      ex_rd_addr_i   = '0;
      branch_taken_i = 1'b1;
      mem_req_i      = 1'b1;
      mem_ack_i      = 1'b0;
      modelReset();
      @(posedge clk_i);
      #1;
      applyReset();

      $display("[TB] load-use on rs2 and x0 cases");
      applyStimulus(5'd3, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
      checkOutput("lu_stall_cnt", 32'(stall_cnt_o), 32'd1);
      applyStimulus(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      applyStimulus(5'd7, 5'd4, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
      applyStimulus(5'd7, 5'd4, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);

      $display("[TB] three-cycle memory wait");
      applyReset();
      repeat (3) applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
      checkOutput("wait_stall_cnt", 32'(stall_cnt_o), 32'd3);
      idleCycle();

      $display("[TB] simultaneous stall, load-use and branch");
      applyStimulus(5'd9, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0);
      applyStimulus(5'd9, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1, 1'b1);
      applyStimulus(5'd9, 5'd9, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);

      $display("[TB] wait timeout");
      repeat (300) applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      checkOutput("timeout_set", 32'(timeout_o), 32'd1);
      applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
      repeat (3) idleCycle();
      checkOutput("timeout_sticky", 32'(timeout_o), 32'd1);

      $display("[TB] reset mid-wait");
      repeat (4) applyStimulus(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      applyReset();
      repeat (2) idleCycle();
      checkOutput("post_rst_hold", 32'(pipe_hold_o), 32'd0);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 600; i++) begin
         if (mWaiting) begin
            req = 1'b1;
            ack = ($urandom_range(0, 3) == 0);
         end else begin
            req = ($urandom_range(0, 3) == 0);
            ack = ($urandom_range(0, 2) == 0);
         end
         br      = ($urandom_range(0, 2) == 0);
         memread = ($urandom_range(0, 1) == 0);
         applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), memread,
                       5'($urandom_range(0, 3)), br, req, ack);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
